// File: rtl/rr_arbiter_7to3.sv
// Round-robin arbiter for 7 requesters with a registered 3-bit grant code (0 = none).
// One cycle req->grant; grants are held until done/drop, with optional forced rotation.
module rr_arbiter_7to3 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] req,
  input  logic       done,
  output logic [2:0] out,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT  = {CNT_W{1'b1}};

  state_t           state, state_nxt;
  logic [2:0]       code_q, code_nxt;
  logic [2:0]       last_q, last_nxt;
  logic [CNT_W-1:0] hold_q, hold_nxt;

  logic [2:0] owner;
  logic [6:0] others;
  logic       preempt;
  logic       release_now;
  logic [3:0] pick_res;

  function automatic logic [2:0] inc7(input logic [2:0] x);
    return (x == 3'd6) ? 3'd0 : x + 3'd1;
  endfunction

  // Returns {found, index}; scans start, start+1, ... modulo 7, lowest offset wins.
  function automatic logic [3:0] pick(input logic [6:0] r, input logic [2:0] start);
    logic [3:0] res;
    logic [3:0] s;
    res = 4'd0;
    for (int k = 6; k >= 0; k--) begin
      s = {1'b0, start} + 4'(k);
      if (s >= 4'd7) s = s - 4'd7;
      if (r[s[2:0]]) res = {1'b1, s[2:0]};
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      code_q <= 3'd0;
      last_q <= 3'd6;
      hold_q <= '0;
    end else begin
      state  <= state_nxt;
      code_q <= code_nxt;
      last_q <= last_nxt;
      hold_q <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    code_nxt    = code_q;
    last_nxt    = last_q;
    hold_nxt    = hold_q;
    owner       = code_q - 3'd1;
    others      = req & ~(7'd1 << owner);
    preempt     = 1'b0;
    release_now = 1'b0;
    pick_res    = 4'd0;
    case (state)
      IDLE: begin
        pick_res = pick(req, inc7(last_q));
        if (pick_res[3]) begin
          code_nxt  = pick_res[2:0] + 3'd1;
          hold_nxt  = '0;
          state_nxt = GRANT;
        end else begin
          code_nxt = 3'd0;
        end
      end
      GRANT: begin
        // Forced rotation only makes sense when someone else is waiting.
        preempt     = (MAX_HOLD != 0) && (hold_q == HOLD_LAST) && (|others);
        release_now = done || !req[owner] || preempt;
        if (release_now) begin
          last_nxt = owner;
          pick_res = pick(preempt ? others : req, inc7(owner));
          if (pick_res[3]) begin
            code_nxt = pick_res[2:0] + 3'd1;
            hold_nxt = '0;
          end else begin
            code_nxt  = 3'd0;
            hold_nxt  = '0;
            state_nxt = IDLE;
          end
        end else if (hold_q != HOLD_SAT) begin
          hold_nxt = hold_q + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out  = code_q;
    busy = (state == GRANT);
  end

endmodule

// File: tb/tb_rr_arbiter_7to3.sv
// Randomized and directed bench for rr_arbiter_7to3 with a queue-based scoreboard.
module tb_rr_arbiter_7to3;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] req;
  logic       done;
  logic [2:0] out;
  logic       busy;

  typedef struct packed {
    logic [2:0] out;
    logic       busy;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: owner index (-1 = none), last releaser, cycles owned.
  int m_owner = -1;
  int m_last  = 6;
  int m_held  = 0;

  rr_arbiter_7to3 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .done (done),
    .out  (out),
    .busy (busy)
  );

  always #5 clk = ~clk;

  function automatic int pick_m(input logic [6:0] r, input int start);
    for (int k = 0; k < 7; k++) begin
      if (r[(start + k) % 7]) return (start + k) % 7;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [6:0] r, input logic d, input logic rs);
    logic [6:0] oth;
    bit         pre;
    int         p;
    if (!rs) begin
      m_owner = -1; m_last = 6; m_held = 0;
    end else if (m_owner < 0) begin
      p = pick_m(r, (m_last + 1) % 7);
      if (p >= 0) begin m_owner = p; m_held = 1; end
    end else begin
      oth = r;
      oth[m_owner] = 1'b0;
      pre = (MAX_HOLD != 0) && (m_held == MAX_HOLD) && (oth != 7'd0);
      if (d || !r[m_owner] || pre) begin
        m_last  = m_owner;
        p       = pick_m(pre ? oth : r, (m_owner + 1) % 7);
        m_owner = p;
        m_held  = (p >= 0) ? 1 : 0;
      end else begin
        m_held++;
      end
    end
  endtask

  // Drive one cycle of stimulus, queue the model's expectation, return after the edge.
  task automatic cyc(input logic [6:0] r, input logic d, input logic rs);
    exp_t e;
    @(negedge clk);
    req = r; done = d; rst_n = rs;
    model_step(r, d, rs);
    e.out  = 3'(m_owner + 1);
    e.busy = (m_owner >= 0);
    sbq.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every registered output update is compared against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        total++;
        if (out !== e.out || busy !== e.busy) begin
          bad++;
          $display("FAIL scoreboard @%0t: out=%0d busy=%0b expected out=%0d busy=%0b",
                   $time, out, busy, e.out, e.busy);
        end
      end
    end
  end

  initial begin
    int wait_cnt;
    req = 7'd0; done = 1'b0; rst_n = 1'b0;

    // Reset with all requests active
    cyc(7'h7F, 1'b0, 1'b0);
    cyc(7'h7F, 1'b0, 1'b0);
    chk("reset_out", out, 0);
    chk("reset_busy", busy, 0);
    cyc(7'h7F, 1'b0, 1'b1);
    chk("first_grant", out, 1);

    // Rotation with done every third cycle
    for (int k = 0; k < 8; k++) begin
      cyc(7'h7F, 1'b0, 1'b1);
      chk("rot_hold_a", out, (k % 7) + 1);
      cyc(7'h7F, 1'b0, 1'b1);
      chk("rot_hold_b", out, (k % 7) + 1);
      cyc(7'h7F, 1'b1, 1'b1);
      chk("rot_next", out, ((k + 1) % 7) + 1);
      chk("rot_busy", busy, 1);
    end

    // Preemption between requesters 0 and 4
    cyc(7'h7F, 1'b0, 1'b0);
    cyc(7'b0010001, 1'b0, 1'b1);
    chk("pre_first", out, 1);
    for (int i = 1; i < 8; i++) begin
      cyc(7'b0010001, 1'b0, 1'b1);
      chk("pre_hold1", out, 1);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(7'b0010001, 1'b0, 1'b1);
      chk("pre_hold5", out, 5);
    end
    cyc(7'b0010001, 1'b0, 1'b1);
    chk("pre_back", out, 1);

    // Release by dropping the request
    cyc(7'h00, 1'b0, 1'b0);
    cyc(7'h08, 1'b0, 1'b1);
    chk("drop_grant", out, 4);
    cyc(7'h00, 1'b0, 1'b1);
    chk("drop_out", out, 0);
    chk("drop_busy", busy, 0);
    cyc(7'h04, 1'b0, 1'b1);
    chk("drop_regrant", out, 3);

    // Sole requester keeps the grant through done and hold expiry
    cyc(7'h40, 1'b0, 1'b1);
    chk("sole_grant", out, 7);
    cyc(7'h40, 1'b1, 1'b1);
    chk("sole_done", out, 7);
    for (int i = 0; i < 12; i++) cyc(7'h40, 1'b0, 1'b1);
    chk("sole_expiry", out, 7);

    // Reset in the middle of a grant
    cyc(7'h10, 1'b0, 1'b1);
    chk("mid_grant", out, 5);
    cyc(7'h10, 1'b0, 1'b0);
    chk("mid_reset", out, 0);
    cyc(7'b0010001, 1'b0, 1'b1);
    chk("mid_after", out, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] r;
      logic       d;
      logic       rs;
      r  = 7'($urandom);
      if ($urandom_range(0, 3) == 0) r = r & 7'($urandom);
      if ($urandom_range(0, 7) == 0) r = 7'd0;
      d  = ($urandom_range(0, 5) == 0);
      rs = ($urandom_range(0, 99) != 0);
      cyc(r, d, rs);
    end

    wait_cnt = 0;
    while (sbq.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    chk("sb_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
